// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Moore-style main controller for a multicycle RV32I datapath that shares a
// single ALU and a unified memory across instruction phases. It latches the
// fetched instruction, steps through fetch/decode/execute/memory/writeback,
// and drives every datapath select and write enable. Memory phases wait on
// MemReady.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   ReadData   in   [31:0] memory read data (instruction during FETCH)
//   MemReady   in   memory access completes this cycle
//   BrTaken    in   branch comparator result (used only in BRANCH)
//   Instr      out  [31:0] latched instruction register
//   ImmSrc     out  [2:0] immediate format for the immediate generator
//   IRWrite    out  load Instr from ReadData
//   PCWrite    out  PC <- result bus
//   AdrSrc     out  memory address select (0=PC, 1=ALUOut)
//   MemWrite   out  memory write strobe
//   RegWrite   out  register file write enable
//   ResultSrc  out  [1:0] result bus select
//   ALUSrcA    out  [1:0] ALU A select
//   ALUSrcB    out  [1:0] ALU B select
//   ALUOp      out  [1:0] ALU operation class
//   Illegal    out  one-cycle pulse in DECODE on unsupported opcode
//   State      out  [3:0] current state code
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter logic [31:0] RESET_IR = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ReadData,
    input  logic        MemReady,
    input  logic        BrTaken,
    output logic [31:0] Instr,
    output logic [2:0]  ImmSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic        Illegal,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [6:0]  opcode;

    assign opcode = instr_q[6:0];
    assign Instr  = instr_q;
    assign State  = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            instr_q <= RESET_IR;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    // Immediate format depends only on the latched opcode.
    always_comb begin
        ImmSrc = 3'b111;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: ImmSrc = 3'b000;
            OP_STORE:                 ImmSrc = 3'b001;
            OP_LUI, OP_AUIPC:         ImmSrc = 3'b010;
            OP_BRANCH:                ImmSrc = 3'b101;
            OP_JAL:                   ImmSrc = 3'b110;
            default:                  ImmSrc = 3'b111;
        endcase
    end

    always_comb begin
        state_d   = S_FETCH;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        Illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                // IRWrite is masked by reset so the instruction register
                // strobe drops the moment reset is applied; PCWrite is not.
                IRWrite   = MemReady & ~reset;
                PCWrite   = MemReady;
                state_d   = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_IMM:            state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_ALUWB;
                    default: begin
                        Illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = MemReady ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                state_d  = MemReady ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b00;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                PCWrite = BrTaken;
                state_d = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target already in ALUOut while the ALU forms
                // OldPC+4 for the link write in ALUWB.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = S_JAL;
            end
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
                state_d = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign instr_d = IRWrite ? ReadData : instr_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic        clk;
    logic        reset;
    logic [31:0] ReadData;
    logic        MemReady;
    logic        BrTaken;
    logic [31:0] Instr;
    logic [2:0]  ImmSrc;
    logic        IRWrite;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ALUOp;
    logic        Illegal;
    logic [3:0]  State;

    int checks = 0;
    int errors = 0;

    multicycle_control #(.RESET_IR(32'h00000013)) dut (
        .clk       (clk),
        .reset     (reset),
        .ReadData  (ReadData),
        .MemReady  (MemReady),
        .BrTaken   (BrTaken),
        .Instr     (Instr),
        .ImmSrc    (ImmSrc),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .RegWrite  (RegWrite),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .Illegal   (Illegal),
        .State     (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        MemReady = 1'b1;
        BrTaken  = 1'b0;
        ReadData = 32'h002081B3;   // add x3,x1,x2
        #12;
        @(negedge clk);
        check("rst_state",    State,    0);
        check("rst_instr",    Instr,    32'h00000013);
        check("rst_immsrc",   ImmSrc,   3'b000);
        check("rst_irwrite",  IRWrite,  0);
        check("rst_pcwrite",  PCWrite,  1);
        check("rst_memwrite", MemWrite, 0);
        check("rst_regwrite", RegWrite, 0);
        reset = 1'b0;
        #1;
        check("add_f_state",   State,   0);
        check("add_f_irwrite", IRWrite, 1);
        check("add_f_alusrcb", ALUSrcB, 2'b10);
        step(); check("add_d_state", State, 1);
        check("add_instr",  Instr,  32'h002081B3);
        check("add_immsrc", ImmSrc, 3'b111);
        check("add_d_irwrite", IRWrite, 0);
        step(); check("add_x_state", State, 6);
        check("add_x_aluop",    ALUOp,    2'b10);
        check("add_x_regwrite", RegWrite, 0);
        step(); check("add_wb_state", State, 8);
        check("add_wb_regwrite", RegWrite, 1);
        step(); check("add_end_state", State, 0);

        // lw with two stalled MEMREAD cycles
        ReadData = 32'h0040A183;
        step(); check("lw_d_state", State, 1);
        check("lw_immsrc", ImmSrc, 3'b000);
        step(); check("lw_ma_state", State, 2);
        check("lw_ma_alusrca", ALUSrcA, 2'b10);
        MemReady = 1'b0;
        step(); check("lw_mr1_state", State, 3);
        check("lw_mr1_adrsrc", AdrSrc, 1);
        check("lw_mr1_regwrite", RegWrite, 0);
        step(); check("lw_mr2_state", State, 3);
        check("lw_mr2_adrsrc", AdrSrc, 1);
        step(); check("lw_mr3_state", State, 3);
        check("lw_mr3_adrsrc", AdrSrc, 1);
        MemReady = 1'b1;
        step(); check("lw_wb_state", State, 4);
        check("lw_wb_regwrite",  RegWrite,  1);
        check("lw_wb_resultsrc", ResultSrc, 2'b01);
        check("lw_wb_adrsrc",    AdrSrc,    0);
        step(); check("lw_end_state", State, 0);

        // sw, no stall
        ReadData = 32'h0030A223;
        step(); check("sw_immsrc", ImmSrc, 3'b001);
        step(); check("sw_ma_state", State, 2);
        check("sw_ma_memwrite", MemWrite, 0);
        step(); check("sw_mw_state", State, 5);
        check("sw_mw_memwrite", MemWrite, 1);
        check("sw_mw_regwrite", RegWrite, 0);
        step(); check("sw_end_state", State, 0);
        check("sw_end_memwrite", MemWrite, 0);

        // beq taken then not taken
        ReadData = 32'h00208463;
        BrTaken  = 1'b1;
        step(); check("beq1_immsrc", ImmSrc, 3'b101);
        check("beq1_d_pcwrite", PCWrite, 0);
        step(); check("beq1_br_state", State, 9);
        check("beq1_br_pcwrite", PCWrite, 1);
        check("beq1_br_aluop",   ALUOp,   2'b01);
        step(); check("beq1_end_state", State, 0);
        BrTaken = 1'b0;
        step(); check("beq2_d_state", State, 1);
        step(); check("beq2_br_state", State, 9);
        check("beq2_br_pcwrite", PCWrite, 0);
        step(); check("beq2_end_state", State, 0);

        // jal then jalr
        ReadData = 32'h008000EF;
        BrTaken  = 1'b1;   // must be ignored outside BRANCH
        step(); check("jal_immsrc", ImmSrc, 3'b110);
        check("jal_d_pcwrite", PCWrite, 0);
        step(); check("jal_j_state", State, 10);
        check("jal_j_pcwrite", PCWrite, 1);
        check("jal_j_alusrcb", ALUSrcB, 2'b10);
        step(); check("jal_wb_state", State, 8);
        check("jal_wb_pcwrite",  PCWrite,  0);
        check("jal_wb_regwrite", RegWrite, 1);
        ReadData = 32'h000080E7;
        step(); check("jalr_f_state", State, 0);
        check("jalr_f_pcwrite", PCWrite, 1);
        step(); check("jalr_immsrc", ImmSrc, 3'b000);
        step(); check("jalr_jr_state", State, 11);
        check("jalr_jr_pcwrite", PCWrite, 0);
        step(); check("jalr_j_state", State, 10);
        check("jalr_j_pcwrite", PCWrite, 1);
        step(); check("jalr_wb_state", State, 8);
        step(); check("jalr_end_state", State, 0);
        BrTaken = 1'b0;

        // lui x3
        ReadData = 32'h000001B7;
        step(); check("lui_immsrc", ImmSrc, 3'b010);
        step(); check("lui_state", State, 12);
        check("lui_alusrca", ALUSrcA, 2'b11);
        step(); check("lui_wb_state", State, 8);
        step(); check("lui_end_state", State, 0);

        // illegal opcode
        ReadData = 32'h0000007F;
        step(); check("ill_d_state", State, 1);
        check("ill_pulse",  Illegal, 1);
        check("ill_immsrc", ImmSrc,  3'b111);
        step(); check("ill_end_state", State, 0);
        check("ill_end_pulse", Illegal, 0);

        // reset in the middle of a stalled store
        ReadData = 32'h0030A223;
        step(); check("rsw_d_state", State, 1);
        step(); check("rsw_ma_state", State, 2);
        MemReady = 1'b0;
        step(); check("rsw_mw1_memwrite", MemWrite, 1);
        step(); check("rsw_mw2_state", State, 5);
        check("rsw_mw2_memwrite", MemWrite, 1);
        #2 reset = 1'b1;
        #1;
        check("rsw_rst_memwrite", MemWrite, 0);
        check("rsw_rst_state",    State,    0);
        check("rsw_rst_instr",    Instr,    32'h00000013);
        check("rsw_rst_irwrite",  IRWrite,  0);
        check("rsw_rst_pcwrite",  PCWrite,  0);
        @(negedge clk);
        reset = 1'b0;
        step(); check("rsw_stall_state", State, 0);
        check("rsw_stall_irwrite", IRWrite, 0);
        MemReady = 1'b1;
        #1;
        check("rsw_fetch_irwrite", IRWrite, 1);
        step(); check("rsw_refetch_instr", Instr, 32'h0030A223);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
